// File: rtl/mure_pkg.sv
// Shared types for the commit-to-trace connector: itype encoding, uop entry and group layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mure_pkg;

  localparam int unsigned NrRetiredInstr = 4;
  localparam int unsigned UopXlen        = 64;

  // E-Trace instruction type, 3-bit encoding.
  typedef enum logic [2:0] {
    ITYPE_STD  = 3'd0,
    ITYPE_EXC  = 3'd1,
    ITYPE_INT  = 3'd2,
    ITYPE_ERET = 3'd3,
    ITYPE_NTB  = 3'd4,
    ITYPE_TB   = 3'd5,
    ITYPE_UJ   = 3'd6
  } itype_e;

  // One retirement; an all-zero entry means "no instruction".
  typedef struct packed {
    logic [UopXlen-1:0] pc;
    itype_e             itype;
    logic               compressed;
    logic [UopXlen-1:0] cause;
    logic [UopXlen-1:0] tval;
  } uop_entry_s;

  // One commit cycle; ivalids bit 3 belongs to port 0 (entry A), uops[k] to port k.
  typedef struct packed {
    logic [NrRetiredInstr-1:0]       ivalids;
    uop_entry_s [NrRetiredInstr-1:0] uops;
  } uop_group_s;

endpackage

// File: rtl/uop_classifier.sv
// Classifies one commit port's retirement into an itype and packs a uop entry.
// Latency: purely combinational.
// Backpressure: none; an invalid port yields an all-zero entry.
module uop_classifier
  import mure_pkg::*;
(
  input  logic               valid,
  input  logic [UopXlen-1:0] pc,
  input  logic               compressed,
  input  logic               is_branch,
  input  logic               branch_taken,
  input  logic               is_ujump,
  input  logic               is_eret,
  input  logic               exc_valid,
  input  logic [UopXlen-1:0] exc_cause,
  input  logic [UopXlen-1:0] exc_tval,
  output uop_entry_s         entry
);

  // Priority classification; trap info is only carried for trapping retirements.
  always_comb begin
    entry = '0;
    if (valid) begin
      entry.pc         = pc;
      entry.compressed = compressed;
      if (exc_valid) begin
        entry.cause = exc_cause;
        entry.tval  = exc_tval;
        entry.itype = exc_cause[UopXlen-1] ? ITYPE_INT : ITYPE_EXC;
      end else if (is_eret) begin
        entry.itype = ITYPE_ERET;
      end else if (is_branch) begin
        entry.itype = branch_taken ? ITYPE_TB : ITYPE_NTB;
      end else if (is_ujump) begin
        entry.itype = ITYPE_UJ;
      end else begin
        entry.itype = ITYPE_STD;
      end
    end
  end

endmodule

// File: rtl/commit_uop_fifo.sv
// Captures each cycle's commit group, classifies it and buffers whole groups for ingress_fsm.
// Latency: a pushed group is visible on the head outputs one cycle later when the FIFO was empty.
// Backpressure: none upstream; a group arriving while full without a pop is dropped and overflow sticks.
module commit_uop_fifo #(
  parameter int unsigned NrRetiredInstr = 4,
  parameter int unsigned FifoDepth      = 8,
  parameter int unsigned XLEN           = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrRetiredInstr-1:0]            commit_valid_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]  commit_pc_i,
  input  logic [NrRetiredInstr-1:0]            commit_compressed_i,
  input  logic [NrRetiredInstr-1:0]            commit_is_branch_i,
  input  logic [NrRetiredInstr-1:0]            commit_branch_taken_i,
  input  logic [NrRetiredInstr-1:0]            commit_is_ujump_i,
  input  logic [NrRetiredInstr-1:0]            commit_is_eret_i,
  input  logic [NrRetiredInstr-1:0]            commit_exc_valid_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]  commit_exc_cause_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]  commit_exc_tval_i,
  input  logic                                 pop_i,
  output logic [NrRetiredInstr-1:0]            ivalids_o,
  output mure_pkg::uop_entry_s                 uop_a_o,
  output mure_pkg::uop_entry_s                 uop_b_o,
  output mure_pkg::uop_entry_s                 uop_c_o,
  output mure_pkg::uop_entry_s                 uop_d_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic [$clog2(FifoDepth):0]           fill_o,
  output logic                                 overflow_o
);
  import mure_pkg::*;

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned FillW = PtrW + 1;

  if (NrRetiredInstr != 4) begin : g_bad_ports
    $error("commit_uop_fifo: only NrRetiredInstr == 4 is supported");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("commit_uop_fifo: FifoDepth must be a power of two >= 2");
  end
  if (XLEN != UopXlen) begin : g_bad_xlen
    $error("commit_uop_fifo: XLEN must match the uop entry width");
  end

  uop_entry_s [NrRetiredInstr-1:0] entries;
  uop_group_s                      push_group;
  uop_group_s                      head_group;
  uop_group_s                      mem_q [FifoDepth];
  logic [PtrW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]                fill_q;
  logic                            overflow_q;
  logic                            push_req, push_ok, pop_ok;

  for (genvar k = 0; k < NrRetiredInstr; k++) begin : g_port
    uop_classifier u_classifier (
      .valid        (commit_valid_i[k]),
      .pc           (commit_pc_i[k]),
      .compressed   (commit_compressed_i[k]),
      .is_branch    (commit_is_branch_i[k]),
      .branch_taken (commit_branch_taken_i[k]),
      .is_ujump     (commit_is_ujump_i[k]),
      .is_eret      (commit_is_eret_i[k]),
      .exc_valid    (commit_exc_valid_i[k]),
      .exc_cause    (commit_exc_cause_i[k]),
      .exc_tval     (commit_exc_tval_i[k]),
      .entry        (entries[k])
    );
  end

  // Assemble the group as presented: gaps kept, port 0 lands on the MSB of ivalids.
  always_comb begin
    push_group = '0;
    for (int k = 0; k < NrRetiredInstr; k++) begin
      push_group.ivalids[NrRetiredInstr-1-k] = commit_valid_i[k];
      push_group.uops[k]                     = entries[k];
    end
  end

  assign empty_o  = (fill_q == '0);
  assign full_o   = (fill_q == FillW'(FifoDepth));
  assign push_req = |commit_valid_i;
  assign pop_ok   = pop_i && !empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts when popping.
  assign push_ok  = push_req && (!full_o || pop_i);

  // Group storage; contents are qualified by fill, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= push_group;
    end
  end

  // Pointers, fill count and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      fill_q <= fill_q + FillW'(1);
      else if (!push_ok && pop_ok) fill_q <= fill_q - FillW'(1);
      if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Head view is masked when empty so stale storage never leaks out.
  always_comb begin
    head_group = '0;
    if (!empty_o) head_group = mem_q[rd_ptr_q];
  end

  assign ivalids_o  = head_group.ivalids;
  assign uop_a_o    = head_group.uops[0];
  assign uop_b_o    = head_group.uops[1];
  assign uop_c_o    = head_group.uops[2];
  assign uop_d_o    = head_group.uops[3];
  assign fill_o     = fill_q;
  assign overflow_o = overflow_q;

endmodule
